// File: rtl/reg_datapath_if.sv
// Operation request, register-file load/read port and status for reg_datapath.
interface reg_datapath_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             start;
  logic [3:0]       op;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [AW-1:0]    rc;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    input  rd_data, busy, done, err, hi, lo
  );

  modport slave (
    input  start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    output rd_data, busy, done, err, hi, lo
  );
endinterface

// File: rtl/reg_datapath.sv
// Single-bus register datapath: three-step sequencer moving R[rb] -> Ry,
// alu(Ry, R[rc]) -> Z, Zlo -> R[ra] over one shared internal bus.
//
// state  | meaning
// IDLE   | waiting; external loads accepted, start begins an operation
// T1     | bus = R[rb], Ry loaded
// T2     | bus = R[rc], Z loaded from the ALU
// T3     | bus = Zlo, written back to R[ra] (and HI/LO for MUL)
module reg_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic           clock,
  input  logic           clear,
  reg_datapath_if.slave  dp
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [AW-1:0]      ra_q, ra_d;
  logic [AW-1:0]      rb_q, rb_d;
  logic [AW-1:0]      rc_q, rc_d;
  logic [WIDTH-1:0]   ry_q, ry_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   ibus;
  logic [2*WIDTH-1:0] alu_z;
  logic               alu_ill;
  logic [SW-1:0]      shamt;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;

  // Exactly one source drives the shared bus in each state.
  always_comb begin
    ibus = '0;
    case (state_q)
      S_T1:    ibus = regs_q[rb_q];
      S_T2:    ibus = regs_q[rc_q];
      S_T3:    ibus = z_q[WIDTH-1:0];
      default: ibus = '0;
    endcase
  end

  assign shamt = ibus[SW-1:0];
  assign mul_a = {{WIDTH{1'b0}}, ry_q};
  assign mul_b = {{WIDTH{1'b0}}, ibus};

  always_comb begin
    alu_z   = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_z = {{WIDTH{1'b0}}, ry_q + ibus};
      OP_SUB:  alu_z = {{WIDTH{1'b0}}, ry_q - ibus};
      OP_AND:  alu_z = {{WIDTH{1'b0}}, ry_q & ibus};
      OP_OR:   alu_z = {{WIDTH{1'b0}}, ry_q | ibus};
      OP_SHL:  alu_z = {{WIDTH{1'b0}}, ry_q << shamt};
      OP_SHR:  alu_z = {{WIDTH{1'b0}}, ry_q >> shamt};
      OP_NOT:  alu_z = {{WIDTH{1'b0}}, ~ry_q};
      OP_MUL:  alu_z = mul_a * mul_b;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    ry_d    = ry_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dp.ld_en) regs_d[dp.ld_addr] = dp.ld_data;
        if (dp.start) begin
          op_d    = dp.op;
          ra_d    = dp.ra;
          rb_d    = dp.rb;
          rc_d    = dp.rc;
          state_d = S_T1;
        end
      end
      S_T1: begin
        ry_d    = ibus;
        state_d = S_T2;
      end
      S_T2: begin
        z_d     = alu_z;
        done_d  = 1'b1;
        err_d   = alu_ill;
        state_d = S_T3;
      end
      default: begin
        regs_d[ra_q] = ibus;
        if (op_q == OP_MUL) begin
          hi_d = z_q[2*WIDTH-1:WIDTH];
          lo_d = ibus;
        end
        // The done cycle also accepts the next request for back-to-back issue.
        if (dp.start) begin
          op_d    = dp.op;
          ra_d    = dp.ra;
          rb_d    = dp.rb;
          rc_d    = dp.rc;
          state_d = S_T1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      ry_q    <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      ry_q    <= ry_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dp.rd_data = regs_q[dp.rd_addr];
  assign dp.busy    = (state_q != S_IDLE);
  assign dp.done    = done_q;
  assign dp.err     = err_q;
  assign dp.hi      = hi_q;
  assign dp.lo      = lo_q;
endmodule
